// File: rtl/ifetch.sv
// Instruction fetch unit: program-load memory, PC sequencing and IDLE/RUN/HALT control.
// Instructions are read combinationally from the word-indexed imem while running.
module ifetch #(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          load_en,
   input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
   input  logic [31:0]                   load_data,
   input  logic                          stall,
   input  logic                          branch_taken,
   input  logic [31:0]                   branch_offset,
   output logic [31:0]                   instr,
   output logic [31:0]                   pc,
   output logic [31:0]                   pc_plus4,
   output logic                          valid,
   output logic                          halted
);

   localparam int unsigned AW = $clog2(IMEM_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t      state, stateNext;
   logic [31:0] pcReg, pcNext;
   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] memWord;

   // Only the word-index bits address imem, so out-of-range PCs alias.
   assign memWord = imem[pcReg[AW+1:2]];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         pcReg <= '0;
      end else begin
         state <= stateNext;
         pcReg <= pcNext;
      end
   end

   // No reset on the array: a loaded program survives reset.
   always_ff @(posedge clk) begin
      if (reset && state == IDLE && load_en)
         imem[load_addr] <= load_data;
   end

   always_comb begin
      stateNext = state;
      pcNext    = pcReg;
      case (state)
         IDLE: begin
            if (start) begin
               stateNext = RUN;
               pcNext    = '0;
            end
         end
         RUN: begin
            if (!stall) begin
               if (memWord == HALT_WORD)
                  stateNext = HALT;
               else if (branch_taken)
                  pcNext = pcReg + 32'd4 + (branch_offset << 2);
               else
                  pcNext = pcReg + 32'd4;
            end
         end
         HALT:    stateNext = HALT;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      valid    = (state == RUN);
      halted   = (state == HALT);
      instr    = (state == RUN) ? memWord : '0;
      pc       = pcReg;
      pc_plus4 = pcReg + 32'd4;
   end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed program table, corner sequences and
// randomized traffic against a behavioural fetch model.
module tb_ifetch;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] HALTW = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        reset, start, load_en, stall, branch_taken;
   logic [7:0]  load_addr;
   logic [31:0] load_data, branch_offset;
   logic [31:0] instr, pc, pc_plus4;
   logic        valid, halted;

   int checks = 0;
   int errors = 0;

   // Behavioural model: mode 0 = waiting for start, 1 = fetching, 2 = stopped.
   logic [31:0] mMem [DEPTH];
   logic [31:0] mPc;
   int          mMode;

   typedef struct {
      logic        st, ld, stl, bt;
      logic [7:0]  la;
      logic [31:0] ldd, bo;
      logic [31:0] ePc, eInstr;
      logic        eValid, eHalted;
   } vec_t;
   vec_t tbl [8];

   ifetch #(.IMEM_DEPTH(DEPTH), .HALT_WORD(HALTW)) dut (
      .clk(clk), .reset(reset), .start(start), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .stall(stall),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .valid(valid), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic st, input logic ld, input logic [7:0] la,
                        input logic [31:0] ldd, input logic stl, input logic bt, input logic [31:0] bo);
      reset = rst; start = st; load_en = ld; load_addr = la; load_data = ldd;
      stall = stl; branch_taken = bt; branch_offset = bo;
   endtask

   task automatic checkModel();
      int unsigned idx = (mPc / 4) % DEPTH;
      logic [31:0] eInstr = (mMode == 1) ? mMem[idx] : 32'd0;
      chk("pc", pc, mPc);
      chk("pc_plus4", pc_plus4, mPc + 32'd4);
      chk("instr", instr, eInstr);
      chk("valid", {31'd0, valid}, {31'd0, mMode == 1});
      chk("halted", {31'd0, halted}, {31'd0, mMode == 2});
   endtask

   // Apply the rules of one rising edge to the model using the held inputs.
   task automatic modelEdge();
      int unsigned idx = (mPc / 4) % DEPTH;
      if (!reset) begin
         mMode = 0;
         mPc   = 32'd0;
      end else if (mMode == 0) begin
         if (load_en) mMem[load_addr] = load_data;
         if (start) begin
            mMode = 1;
            mPc   = 32'd0;
         end
      end else if (mMode == 1 && !stall) begin
         if (mMem[idx] == HALTW) mMode = 2;
         else mPc = mPc + 32'd4 + (branch_taken ? branch_offset * 32'd4 : 32'd0);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   // Check mid-cycle against the model, then take the edge.
   task automatic cycle();
      #4;
      checkModel();
      advance();
   endtask

   task automatic runN(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1, 0, 0, 8'd0, 32'd0, 0, 0, 32'd0);
         cycle();
      end
   endtask

   initial begin
      logic [31:0] w;
      drive(0, 0, 0, 8'd0, 32'd0, 0, 0, 32'd0);
      advance();
      checkModel();

      for (int i = 0; i < int'(DEPTH); i++) begin
         w = $urandom;
         if (w == HALTW) w = 32'h0;
         drive(1, 0, 1, 8'(i), w, 0, 0, 32'd0);
         cycle();
      end
      drive(1, 0, 1, 8'd0, 32'h20010005, 0, 0, 32'd0); cycle();
      drive(1, 0, 1, 8'd1, 32'h20020003, 0, 0, 32'd0); cycle();
      drive(1, 0, 1, 8'd2, 32'h00000000, 0, 0, 32'd0); cycle();
      drive(1, 0, 1, 8'd3, 32'hFFFFFFFF, 0, 0, 32'd0); cycle();

      tbl[0] = '{1, 0, 0, 0, 8'd0, 32'd0, 32'd0, 32'd0,  32'h0,        0, 0};
      tbl[1] = '{0, 0, 0, 0, 8'd0, 32'd0, 32'd0, 32'd0,  32'h20010005, 1, 0};
      tbl[2] = '{0, 0, 0, 0, 8'd0, 32'd0, 32'd0, 32'd4,  32'h20020003, 1, 0};
      tbl[3] = '{0, 0, 0, 0, 8'd0, 32'd0, 32'd0, 32'd8,  32'h00000000, 1, 0};
      tbl[4] = '{0, 0, 0, 1, 8'd0, 32'd0, 32'd5, 32'd12, 32'hFFFFFFFF, 1, 0};
      tbl[5] = '{1, 1, 0, 0, 8'd0, 32'd0, 32'd0, 32'd12, 32'h0,        0, 1};
      tbl[6] = '{0, 1, 0, 1, 8'd0, 32'd0, 32'd3, 32'd12, 32'h0,        0, 1};
      tbl[7] = '{1, 0, 0, 0, 8'd0, 32'd0, 32'd0, 32'd12, 32'h0,        0, 1};
      for (int i = 0; i < 8; i++) begin
         drive(1, tbl[i].st, tbl[i].ld, tbl[i].la, tbl[i].ldd, tbl[i].stl, tbl[i].bt, tbl[i].bo);
         #4;
         checkModel();
         chk($sformatf("tbl%0d.pc", i), pc, tbl[i].ePc);
         chk($sformatf("tbl%0d.instr", i), instr, tbl[i].eInstr);
         chk($sformatf("tbl%0d.valid", i), {31'd0, valid}, {31'd0, tbl[i].eValid});
         chk($sformatf("tbl%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].eHalted});
         advance();
      end

      // Reset leaves imem intact; rerun must halt at the same place.
      drive(0, 1, 1, 8'd0, 32'd0, 0, 1, 32'd9); cycle();
      chk("rstHalt.pc", pc, 32'd0);
      chk("rstHalt.halted", {31'd0, halted}, 32'd0);
      drive(1, 1, 0, 8'd0, 32'd0, 0, 0, 32'd0); cycle();
      chk("rerun.instr0", instr, 32'h20010005);
      runN(4);
      chk("rerun.halted", {31'd0, halted}, 32'd1);
      chk("rerun.pc", pc, 32'd12);

      // Clear the halt word with a load in the same cycle as start.
      drive(0, 0, 0, 8'd0, 32'd0, 0, 0, 32'd0); cycle();
      drive(1, 1, 1, 8'd3, 32'h00000000, 0, 0, 32'd0); cycle();
      chk("loadStart.instr0", instr, 32'h20010005);
      runN(8);
      chk("run.pc20", pc, 32'h20);
      drive(0, 0, 0, 8'd0, 32'd0, 1, 1, 32'd3); cycle();
      chk("rstRun.pc", pc, 32'd0);
      chk("rstRun.valid", {31'd0, valid}, 32'd0);
      drive(1, 1, 0, 8'd0, 32'd0, 0, 0, 32'd0); cycle();
      chk("rstRun.rerun", instr, 32'h20010005);

      // Stall holds pc and instr even with a branch pending.
      runN(2);
      chk("stall.pc8", pc, 32'h8);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 8'd0, 32'd0, 1, 1, 32'd7); cycle();
         chk("stall.hold", pc, 32'h8);
         chk("stall.instr", instr, mMem[2]);
      end
      drive(1, 0, 0, 8'd0, 32'd0, 0, 0, 32'd7); cycle();
      chk("stall.release", pc, 32'hC);

      runN(1);
      chk("br.pc10", pc, 32'h10);
      drive(1, 0, 0, 8'd0, 32'd0, 0, 1, 32'hFFFFFFFC); cycle();
      chk("br.back", pc, 32'h04);
      runN(3);
      drive(1, 0, 0, 8'd0, 32'd0, 0, 1, 32'h00000002); cycle();
      chk("br.fwd", pc, 32'h1C);

      // Index aliasing past the end of imem and past address zero.
      drive(0, 0, 0, 8'd0, 32'd0, 0, 0, 32'd0); cycle();
      drive(1, 1, 0, 8'd0, 32'd0, 0, 0, 32'd0); cycle();
      drive(1, 0, 0, 8'd0, 32'd0, 0, 1, 32'd254); cycle();
      chk("alias.pc3fc", pc, 32'h3FC);
      runN(1);
      chk("alias.pc400", pc, 32'h400);
      chk("alias.instr", instr, 32'h20010005);
      chk("alias.valid", {31'd0, valid}, 32'd1);
      drive(1, 0, 0, 8'd0, 32'd0, 0, 1, 32'hFFFFFEFE); cycle();
      chk("wrap.pc", pc, 32'hFFFFFFFC);
      chk("wrap.pc_plus4", pc_plus4, 32'h0);
      chk("wrap.instr", instr, mMem[255]);
      runN(1);
      chk("wrap.pc0", pc, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         w = ($urandom_range(0, 7) == 0) ? HALTW : $urandom;
         drive($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
               8'($urandom), w, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               ($urandom_range(0, 9) == 0) ? $urandom : 32'($signed($urandom_range(0, 16)) - 8));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, number of 32-bit instruction words (power of two).
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, instruction encoding that stops fetch.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse, IDLE to RUN.
REQ-006 SHALL have port load_en  input  1  program-load write strobe.
REQ-007 SHALL have port load_addr  input  log2(IMEM_DEPTH)  program-load word index.
REQ-008 SHALL have port load_data  input  32  program-load word.
REQ-009 SHALL have port stall  input  1  holds PC and instr for this cycle.
REQ-010 SHALL have port branch_taken  input  1  from datapath Branch AND ALU zero.
REQ-011 SHALL have port branch_offset  input  32  sign-extended 16-bit immediate, word units.
REQ-012 SHALL have port instr  output  32  current instruction to datapath/control (OpCode = instr[31:26]).
REQ-013 SHALL have port pc  output  32  byte address of instr.
REQ-014 SHALL have port pc_plus4  output  32  pc + 4.
REQ-015 SHALL have port valid  output  1  instr is a live instruction.
REQ-016 SHALL have port halted  output  1  HALT state indicator.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALT, encoded in a state register.
REQ-018 IDLE: valid=0, instr=0, pc=0; load_en=1 SHALL write load_data to imem[load_addr] on the clock edge.
REQ-019 load_en outside IDLE SHALL be ignored (no write).
REQ-020 IDLE with start=1 SHALL enter RUN next cycle with pc=0; load_en and start in the same cycle: write completes, then RUN.
REQ-021 RUN: instr SHALL equal imem[pc[log2(IMEM_DEPTH)+1:2]] combinationally; valid=1; pc[1:0] and upper bits beyond the index ignored for addressing (aliasing wrap).
REQ-022 RUN, stall=0, branch_taken=0: pc SHALL become pc+4 next cycle.
REQ-023 RUN, stall=0, branch_taken=1: pc SHALL become pc+4+(branch_offset<<2), 32-bit modulo-2^32 arithmetic, no overflow flag.
REQ-024 stall=1 SHALL hold pc, state and instr unchanged and take priority over branch_taken and halt detection.
REQ-025 RUN, stall=0, instr==HALT_WORD: SHALL enter HALT next cycle; pc holds the halt instruction address; branch_taken ignored that cycle.
REQ-026 HALT: valid=0, halted=1, instr=0, pc frozen; start and load_en ignored; only reset exits.
REQ-027 pc_plus4 SHALL always equal pc+4 (wraps 32'hFFFFFFFC to 0).
REQ-028 halted SHALL be 1 only in HALT.
REQ-029 Branch to pc wrapping past address 0 SHALL fetch aliased word per REQ-021, no error.
REQ-030 Memory SHALL not be read-during-write sensitive (writes only in IDLE, reads only in RUN).

Reset
REQ-031 reset=0 at a rising edge SHALL force state=IDLE, pc=0, valid=0, halted=0, instr=0 in the following cycle, from any state, mid-branch or mid-stall.
REQ-032 Reset SHALL not clear imem contents; a program loaded before reset SHALL run again after start.
REQ-033 reset SHALL have priority over start, load_en, stall and branch_taken.

Verification
REQ-034 Load imem[0..3]=0x20010005,0x20020003,0x00000000,0xFFFFFFFF; pulse start -> pc 0,4,8,12 on consecutive cycles, valid=1, then halted=1, pc=12, valid=0.
REQ-035 RUN at pc=0x10, branch_taken=1, branch_offset=0xFFFFFFFC -> next pc=0x04; offset=0x00000002 -> next pc=0x1C.
REQ-036 stall=1 for 3 cycles at pc=0x08 with branch_taken=1 -> pc stays 0x08, instr unchanged; stall released with branch_taken=0 -> pc=0x0C.
REQ-037 reset=0 during RUN at pc=0x20 -> next cycle pc=0, state IDLE, valid=0; start -> program reruns from imem[0] unchanged.
REQ-038 load_en=1 in RUN with load_addr=0, load_data=0 -> imem[0] unchanged after reset and rerun; start in HALT -> remains halted.
REQ-039 pc=0x3FC (IMEM_DEPTH=256) with no branch -> next pc=0x400, instr=imem[0], valid=1.
